fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RV32 core: holds the program counter, reads a word-addressed instruction memory, and registers the fetched instruction and its PC into the EX stage. It supports stall, branch/jump redirect with bubble insertion, runtime program loading, and a delivered-instruction counter. It sits between the instruction memory image and the decode/control/regfile logic of the EX stage.

---
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed imem,
// and the fetch-to-EX pipeline register with stall/redirect.
module fetch_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INST   = 32'h00000013,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            imem_we_i,
  input  logic [AW-1:0]   imem_waddr_i,
  input  logic [31:0]     imem_wdata_i,
  output logic [XLEN-1:0] pc_F_o,
  output logic [31:0]     instruction_EX_o,
  output logic [XLEN-1:0] pc_EX_o,
  output logic            valid_EX_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] fetch_count_o
);

  logic [31:0]     imem [IMEM_DEPTH];
  logic [AW-1:0]   idx;
  logic [31:0]     rd_word;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pcex_q, pcex_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  assign idx     = pc_q[AW+1:2];
  assign rd_word = imem[idx];

  // Program-load port; contents survive reset, reads see old data
  always_ff @(posedge clk) begin
    if (imem_we_i) imem[imem_waddr_i] <= imem_wdata_i;
  end

  // Next state: redirect beats stall beats normal advance
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcex_d  = pcex_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      mis_d   = |redirect_pc_i[1:0];
    end else if (!stall_i) begin
      inst_d  = rd_word;
      pcex_d  = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + XLEN'(4);
      cnt_d   = cnt_q + XLEN'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pcex_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcex_q  <= pcex_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_F_o           = pc_q;
  assign instruction_EX_o = inst_q;
  assign pc_EX_o          = pcex_q;
  assign valid_EX_o       = valid_q;
  assign misalign_o       = mis_q;
  assign fetch_count_o    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 16-word imem
// so index wrap is reachable.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_we_i;
  logic [3:0]  imem_waddr_i;
  logic [31:0] imem_wdata_i;
  logic [31:0] pc_F_o;
  logic [31:0] instruction_EX_o;
  logic [31:0] pc_EX_o;
  logic        valid_EX_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  logic [31:0] img [16];
  int n_chk = 0;
  int n_fail = 0;

  fetch_stage #(
    .XLEN(32),
    .IMEM_DEPTH(16),
    .RESET_PC(32'h0),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_we_i(imem_we_i),
    .imem_waddr_i(imem_waddr_i),
    .imem_wdata_i(imem_wdata_i),
    .pc_F_o(pc_F_o),
    .instruction_EX_o(instruction_EX_o),
    .pc_EX_o(pc_EX_o),
    .valid_EX_o(valid_EX_o),
    .misalign_o(misalign_o),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string tag,
                    input logic [31:0] inst,
                    input logic [31:0] pc,
                    input logic v);
    chk({tag, ".inst"}, instruction_EX_o, inst);
    chk({tag, ".pcex"}, pc_EX_o, pc);
    chk({tag, ".valid"}, {31'b0, valid_EX_o}, {31'b0, v});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) img[i] = 32'hA000_0000 + i;
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_we_i = 1'b0;
    imem_waddr_i = '0;
    imem_wdata_i = '0;
    #1;
    for (int i = 0; i < 16; i++) begin
      imem_we_i = 1'b1;
      imem_waddr_i = 4'(i);
      imem_wdata_i = img[i];
      step();
    end
    imem_we_i = 1'b0;
    step();
    chk("rst.pcF", pc_F_o, 32'h0);
    ex("rst", NOP, 32'h0, 1'b0);
    chk("rst.mis", {31'b0, misalign_o}, 32'h0);
    chk("rst.cnt", fetch_count_o, 32'h0);

    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      ex("run", img[k], 32'(4 * k), 1'b1);
      chk("run.pcF", pc_F_o, 32'(4 * k + 4));
    end
    chk("run.cnt", fetch_count_o, 32'd4);

    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ex("stall", img[3], 32'd12, 1'b1);
      chk("stall.pcF", pc_F_o, 32'd16);
      chk("stall.cnt", fetch_count_o, 32'd4);
    end
    stall_i = 1'b0;
    step();
    ex("unstall", img[4], 32'd16, 1'b1);
    chk("unstall.cnt", fetch_count_o, 32'd5);

    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    ex("redir", NOP, 32'd16, 1'b0);
    chk("redir.pcF", pc_F_o, 32'h40);
    chk("redir.mis", {31'b0, misalign_o}, 32'h0);
    chk("redir.cnt", fetch_count_o, 32'd5);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    step();
    ex("tgt", img[0], 32'h40, 1'b1);
    chk("tgt.pcF", pc_F_o, 32'h44);
    chk("tgt.cnt", fetch_count_o, 32'd6);

    redirect_i = 1'b1;
    redirect_pc_i = 32'h43;
    step();
    chk("mis.pcF", pc_F_o, 32'h40);
    chk("mis.pulse", {31'b0, misalign_o}, 32'h1);
    ex("mis", NOP, 32'h40, 1'b0);
    redirect_i = 1'b0;
    step();
    chk("mis.clear", {31'b0, misalign_o}, 32'h0);
    ex("mis.tgt", img[0], 32'h40, 1'b1);
    chk("mis.cnt", fetch_count_o, 32'd7);

    redirect_i = 1'b1;
    redirect_pc_i = 32'h14;
    step();
    redirect_i = 1'b0;
    chk("ld.pcF", pc_F_o, 32'h14);
    imem_we_i = 1'b1;
    imem_waddr_i = 4'd5;
    imem_wdata_i = 32'hDEADBEEF;
    step();
    imem_we_i = 1'b0;
    ex("ld.old", img[5], 32'h14, 1'b1);
    img[5] = 32'hDEADBEEF;
    redirect_i = 1'b1;
    step();
    redirect_i = 1'b0;
    step();
    ex("ld.new", 32'hDEADBEEF, 32'h14, 1'b1);
    chk("ld.cnt", fetch_count_o, 32'd9);

    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap.pcF0", pc_F_o, 32'hFFFF_FFFC);
    step();
    ex("wrap", img[15], 32'hFFFF_FFFC, 1'b1);
    chk("wrap.pcF", pc_F_o, 32'h0);
    chk("wrap.cnt", fetch_count_o, 32'd10);

    reset = 1'b1;
    redirect_i = 1'b1;
    stall_i = 1'b1;
    redirect_pc_i = 32'h43;
    step();
    chk("rr.pcF", pc_F_o, 32'h0);
    ex("rr", NOP, 32'h0, 1'b0);
    chk("rr.mis", {31'b0, misalign_o}, 32'h0);
    chk("rr.cnt", fetch_count_o, 32'h0);
    reset = 1'b0;
    redirect_i = 1'b0;
    stall_i = 1'b0;
    step();
    ex("rr.run", img[0], 32'h0, 1'b1);
    chk("rr.runcnt", fetch_count_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
